// File: rtl/icache_if.sv
// Instruction cache bus bundle: processor fetch port plus the memory
// command/response port, grouped so the cache and its environment share
// one connection.
//   slave  : the cache side (drives Icache_* and proc2mem_*)
//   master : the environment side (drives fetch address/valid and mem2proc_*)
interface icache_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] proc2Icache_addr_i;
  logic            read_valid_i;
  logic [63:0]     Icache_data_o;
  logic            Icache_valid_o;
  logic [1:0]      proc2mem_command_o;
  logic [XLEN-1:0] proc2mem_addr_o;
  logic [3:0]      mem2proc_response_i;
  logic [63:0]     mem2proc_data_i;
  logic [3:0]      mem2proc_tag_i;

  modport slave (
    input  proc2Icache_addr_i, read_valid_i,
    input  mem2proc_response_i, mem2proc_data_i, mem2proc_tag_i,
    output Icache_data_o, Icache_valid_o,
    output proc2mem_command_o, proc2mem_addr_o
  );

  modport master (
    output proc2Icache_addr_i, read_valid_i,
    output mem2proc_response_i, mem2proc_data_i, mem2proc_tag_i,
    input  Icache_data_o, Icache_valid_o,
    input  proc2mem_command_o, proc2mem_addr_o
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with 8-byte lines and a single
// outstanding miss to a tagged, split-transaction memory.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : icache_if.slave (fetch request/response, memory command,
//                memory response tag and fill data)
//
// state | meaning
// IDLE  | serve hits; a miss latches the aligned address and starts a load
// REQ   | drive LOAD at miss_addr until memory accepts with a nonzero tag
// WAIT  | wait for the completion tag; capture fill data in that cycle
// FILL  | write the captured line, then re-evaluate the (pending) request
module icache #(
  parameter int CACHE_LINES = 32,
  parameter int XLEN        = 32
) (
  input  logic     clk,
  input  logic     reset,
  icache_if.slave  bus
);
  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = XLEN - 3 - IDX_W;
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

  state_t state_q, state_d;

  logic [CACHE_LINES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_mem  [CACHE_LINES];
  logic [63:0]            data_mem [CACHE_LINES];

  logic            pending_q;
  logic [3:0]      txn_tag_q;
  logic [XLEN-1:0] miss_addr_q;
  logic [63:0]     fill_data_q;

  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             hit, req_active, icache_valid;
  logic             latch_miss, latch_txn, latch_fill, do_fill;
  logic [1:0]       mem_cmd;
  logic [XLEN-1:0]  mem_addr;

  assign req_idx  = bus.proc2Icache_addr_i[3 +: IDX_W];
  assign req_tag  = bus.proc2Icache_addr_i[XLEN-1 -: TAG_W];
  assign miss_idx = miss_addr_q[3 +: IDX_W];
  assign miss_tag = miss_addr_q[XLEN-1 -: TAG_W];

  // Lookup reads the arrays as registered, so a FILL write to the same
  // index only becomes visible in the following cycle.
  assign hit          = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign req_active   = bus.read_valid_i || pending_q;
  assign icache_valid = req_active && hit;

  assign bus.Icache_valid_o     = icache_valid;
  assign bus.Icache_data_o      = data_mem[req_idx];
  assign bus.proc2mem_command_o = mem_cmd;
  assign bus.proc2mem_addr_o    = mem_addr;

  always_comb begin
    state_d    = state_q;
    latch_miss = 1'b0;
    latch_txn  = 1'b0;
    latch_fill = 1'b0;
    do_fill    = 1'b0;
    mem_cmd    = CMD_NONE;
    mem_addr   = '0;
    case (state_q)
      IDLE: begin
        if (req_active && !hit) begin
          state_d    = REQ;
          latch_miss = 1'b1;
        end
      end
      REQ: begin
        mem_cmd  = CMD_LOAD;
        mem_addr = miss_addr_q;
        if (bus.mem2proc_response_i != 4'd0) begin
          state_d   = WAIT;
          latch_txn = 1'b1;
        end
      end
      WAIT: begin
        if (bus.mem2proc_tag_i != 4'd0 && bus.mem2proc_tag_i == txn_tag_q) begin
          state_d    = FILL;
          latch_fill = 1'b1;
        end
      end
      FILL: begin
        do_fill = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      pending_q   <= 1'b0;
      txn_tag_q   <= 4'd0;
      miss_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q <= state_d;
      // Pending remembers a one-cycle request until it has been answered.
      if (icache_valid)
        pending_q <= 1'b0;
      else if (bus.read_valid_i)
        pending_q <= 1'b1;
      if (latch_miss)
        miss_addr_q <= {bus.proc2Icache_addr_i[XLEN-1:3], 3'b000};
      if (latch_txn)
        txn_tag_q <= bus.mem2proc_response_i;
      // Memory data is only valid in the completion cycle.
      if (latch_fill)
        fill_data_q <= bus.mem2proc_data_i;
      if (do_fill)
        valid_q[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_fill) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= fill_data_q;
    end
  end
endmodule

// File: tb/tb_icache.sv
module tb_icache;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [63:0] exp_q[$];

  localparam logic [63:0] D_100 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D_180 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D_200 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D_300 = 64'h9999_0000_1234_5678;
  localparam logic [63:0] JUNK  = 64'hDEAD_BEEF_DEAD_BEEF;

  icache_if #(.XLEN(32)) bus ();

  icache #(.CACHE_LINES(32), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [63:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", name);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({name, "_data"}, bus.Icache_data_o, e);
    end
  endtask

  // Wait for the response after the tag-match cycle; checks latency and data.
  task automatic expect_resp(input string name, input int exp_lat);
    bit seen;
    seen = 1'b0;
    for (int n = 1; n <= 10 && !seen; n++) begin
      tick();
      bus.mem2proc_tag_i  = 4'd0;
      bus.mem2proc_data_i = JUNK;
      #1;
      if (bus.Icache_valid_o === 1'b1) begin
        seen = 1'b1;
        chk({name, "_lat"}, 64'(n), 64'(exp_lat));
        sb_check(name);
      end
    end
    checks++;
    assert (seen) else begin
      failures++;
      $error("FAIL %s_timeout observed=no_valid expected=valid", name);
    end
  endtask

  // Entered in the miss-request cycle; runs REQ (with rejects), WAIT, FILL.
  task automatic miss_fill(input string name, input logic [31:0] addr,
                           input logic [63:0] data, input int rejects,
                           input logic [3:0] resp, input bit bad_tag);
    tick();
    bus.read_valid_i = 1'b0;
    for (int r = 0; r < rejects; r++) begin
      bus.mem2proc_response_i = 4'd0;
      #1;
      chk({name, "_rej_cmd"}, 64'(bus.proc2mem_command_o), 64'd1);
      chk({name, "_rej_addr"}, 64'(bus.proc2mem_addr_o), 64'(addr));
      tick();
    end
    bus.mem2proc_response_i = resp;
    #1;
    chk({name, "_cmd"}, 64'(bus.proc2mem_command_o), 64'd1);
    chk({name, "_addr"}, 64'(bus.proc2mem_addr_o), 64'(addr));
    tick();
    bus.mem2proc_response_i = 4'd0;
    if (bad_tag) begin
      bus.mem2proc_tag_i  = resp + 4'd1;
      bus.mem2proc_data_i = JUNK;
    end
    #1;
    chk({name, "_wait_cmd"}, 64'(bus.proc2mem_command_o), 64'd0);
    tick();
    bus.mem2proc_tag_i  = resp;
    bus.mem2proc_data_i = data;
    #1;
    chk({name, "_tagcyc_valid"}, 64'(bus.Icache_valid_o), 64'd0);
    expect_resp(name, 2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.proc2Icache_addr_i  = '0;
    bus.read_valid_i        = 1'b0;
    bus.mem2proc_response_i = 4'd0;
    bus.mem2proc_data_i     = '0;
    bus.mem2proc_tag_i      = 4'd0;
    repeat (3) tick();
    chk("reset_valid", 64'(bus.Icache_valid_o), 64'd0);
    chk("reset_cmd", 64'(bus.proc2mem_command_o), 64'd0);
    chk("reset_maddr", 64'(bus.proc2mem_addr_o), 64'd0);
    reset = 1'b0;

    // cold miss at 0x104 -> LOAD 0x100
    tick();
    bus.proc2Icache_addr_i = 32'h0000_0104;
    bus.read_valid_i = 1'b1;
    exp_q.push_back(D_100);
    #1;
    chk("cold_valid", 64'(bus.Icache_valid_o), 64'd0);
    chk("cold_idle_cmd", 64'(bus.proc2mem_command_o), 64'd0);
    miss_fill("cold", 32'h100, D_100, 0, 4'd3, 1'b0);

    // hit, zero latency
    tick();
    bus.proc2Icache_addr_i = 32'h0000_0100;
    bus.read_valid_i = 1'b1;
    exp_q.push_back(D_100);
    #1;
    chk("hit_valid", 64'(bus.Icache_valid_o), 64'd1);
    chk("hit_cmd", 64'(bus.proc2mem_command_o), 64'd0);
    sb_check("hit");
    tick();
    bus.read_valid_i = 1'b0;
    #1;
    chk("hit_pending_clear", 64'(bus.Icache_valid_o), 64'd0);

    // rejects then accept, with a foreign tag ignored during WAIT
    tick();
    bus.proc2Icache_addr_i = 32'h0000_0180;
    bus.read_valid_i = 1'b1;
    exp_q.push_back(D_180);
    #1;
    chk("reject_valid", 64'(bus.Icache_valid_o), 64'd0);
    miss_fill("reject", 32'h180, D_180, 3, 4'd5, 1'b1);

    // conflict: 0x200 evicts 0x100 (same index)
    tick();
    bus.proc2Icache_addr_i = 32'h0000_0200;
    bus.read_valid_i = 1'b1;
    exp_q.push_back(D_200);
    #1;
    chk("conflict_valid", 64'(bus.Icache_valid_o), 64'd0);
    miss_fill("conflict", 32'h200, D_200, 0, 4'd4, 1'b0);
    tick();
    bus.proc2Icache_addr_i = 32'h0000_0100;
    bus.read_valid_i = 1'b1;
    #1;
    chk("conflict_evict", 64'(bus.Icache_valid_o), 64'd0);

    // redirect to 0x300 while the 0x100 miss is in flight
    tick();
    bus.read_valid_i = 1'b0;
    bus.mem2proc_response_i = 4'd6;
    #1;
    chk("redir_cmd", 64'(bus.proc2mem_command_o), 64'd1);
    chk("redir_addr", 64'(bus.proc2mem_addr_o), 64'h100);
    tick();
    bus.mem2proc_response_i = 4'd0;
    bus.proc2Icache_addr_i = 32'h0000_0300;
    bus.read_valid_i = 1'b1;
    exp_q.push_back(D_300);
    #1;
    chk("redir_wait_valid", 64'(bus.Icache_valid_o), 64'd0);
    tick();
    bus.read_valid_i = 1'b0;
    bus.mem2proc_tag_i = 4'd6;
    bus.mem2proc_data_i = D_100;
    #1;
    chk("redir_tag_valid", 64'(bus.Icache_valid_o), 64'd0);
    tick();
    bus.mem2proc_tag_i = 4'd0;
    bus.mem2proc_data_i = JUNK;
    #1;
    chk("redir_fill_valid", 64'(bus.Icache_valid_o), 64'd0);
    chk("redir_fill_cmd", 64'(bus.proc2mem_command_o), 64'd0);
    tick();
    #1;
    chk("redir_idle_valid", 64'(bus.Icache_valid_o), 64'd0);
    chk("redir_idle_cmd", 64'(bus.proc2mem_command_o), 64'd0);
    miss_fill("redirect", 32'h300, D_300, 0, 4'd7, 1'b0);

    // reset during WAIT, then the stale completion arrives
    tick();
    bus.proc2Icache_addr_i = 32'h0000_0008;
    bus.read_valid_i = 1'b1;
    #1;
    chk("rst_miss_valid", 64'(bus.Icache_valid_o), 64'd0);
    tick();
    bus.read_valid_i = 1'b0;
    bus.mem2proc_response_i = 4'd9;
    #1;
    chk("rst_miss_cmd", 64'(bus.proc2mem_command_o), 64'd1);
    chk("rst_miss_addr", 64'(bus.proc2mem_addr_o), 64'h8);
    tick();
    bus.mem2proc_response_i = 4'd0;
    reset = 1'b1;
    tick();
    chk("rst_valid", 64'(bus.Icache_valid_o), 64'd0);
    chk("rst_cmd", 64'(bus.proc2mem_command_o), 64'd0);
    chk("rst_maddr", 64'(bus.proc2mem_addr_o), 64'd0);
    reset = 1'b0;
    tick();
    bus.mem2proc_tag_i = 4'd9;
    bus.mem2proc_data_i = JUNK;
    #1;
    chk("stale_cmd", 64'(bus.proc2mem_command_o), 64'd0);
    tick();
    bus.mem2proc_tag_i = 4'd0;
    bus.proc2Icache_addr_i = 32'h0000_0300;
    bus.read_valid_i = 1'b1;
    #1;
    chk("rst_inval_300", 64'(bus.Icache_valid_o), 64'd0);
    tick();
    bus.read_valid_i = 1'b0;
    #1;
    chk("rst_newmiss_cmd", 64'(bus.proc2mem_command_o), 64'd1);
    chk("rst_newmiss_addr", 64'(bus.proc2mem_addr_o), 64'h300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.proc2Icache_addr_i = 32'h0000_0008;
    bus.read_valid_i = 1'b1;
    #1;
    chk("stale_ignored", 64'(bus.Icache_valid_o), 64'd0);
    tick();
    bus.read_valid_i = 1'b0;

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
